set_dispatch: RTL and testbench

- Upstream feeder for the SET circle-set counting engine. Accepts jobs (central, radius, mode) from a host over a valid/ready interface and buffers them in a small FIFO.
- Issues each job to SET with a one-cycle en pulse, but only while SET busy is low. Then waits for SET valid before issuing the next job.
- Tracks completed jobs and flags stalled jobs with a watchdog.

---
 rtl/set_dispatch.sv | 143 ++++++++++++++
 tb/tb_set_dispatch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_dispatch.sv
// set_dispatch: job feeder for the SET circle-set counting engine.
// Buffers host jobs in a small FIFO, issues one job at a time to SET with a
// single-cycle en strobe (only while SET is not busy), waits for SET's result
// strobe, counts completions and flags jobs that stall past a watchdog limit.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          host job handshake
//   in_central/radius/mode     host job payload
//   set_busy, set_valid        status from SET
//   set_en                     one-cycle job strobe to SET
//   set_central/radius/mode    job payload held toward SET
//   done_cnt                   completed-job counter (wraps)
//   tmo_err                    sticky watchdog flag
//   idle                       FIFO empty and nothing in flight
`timescale 1ns/1ps

module set_dispatch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_central,
  input  logic [11:0] in_radius,
  input  logic [1:0]  in_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  output logic [7:0]  done_cnt,
  output logic        tmo_err,
  output logic        idle
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(TMO + 1);

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
  } job_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  job_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [WW-1:0] wd;
  logic [WW-1:0] wd_next;
  logic          push;
  logic          pop;
  job_t          head;

  // Handshake, issue decision and status derived from registered state
  assign in_ready = (count != CW'(DEPTH)) & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) && (count != '0) && !set_busy;
  assign head     = mem[rd_ptr];
  assign wd_next  = wd + WW'(1);
  assign idle     = (state == IDLE) && (count == '0);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{central: in_central, radius: in_radius, mode: in_mode};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Issue sequencer with registered SET-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      set_en      <= 1'b0;
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
      done_cnt    <= '0;
      tmo_err     <= 1'b0;
      wd          <= '0;
    end else begin
      set_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            set_central <= head.central;
            set_radius  <= head.radius;
            set_mode    <= head.mode;
            set_en      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the final watchdog cycle still counts
          if (set_valid) begin
            done_cnt <= done_cnt + 8'd1;
            state    <= GAP;
          end else if (wd_next == WW'(TMO)) begin
            tmo_err <= 1'b1;
            state   <= GAP;
          end else begin
            wd <= wd_next;
          end
        end
        GAP: begin
          // Lets SET drop valid and refresh busy before the next issue
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_dispatch.sv
// Testbench for set_dispatch: directed scenarios plus random traffic.
// A queue holds jobs accepted but not yet issued; a monitor pops it on every
// set_en and compares the issued payload. A small SET model answers each
// strobe after a chosen latency and tallies expected completions.
`timescale 1ns/1ps

module tb_set_dispatch;

  localparam int DEPTH = 4;
  localparam int TMO   = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_central = '0;
  logic [11:0] in_radius = '0;
  logic [1:0]  in_mode = '0;
  logic        set_busy = 1'b0;
  logic        set_valid = 1'b0;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic [7:0]  done_cnt;
  logic        tmo_err;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;

  logic [37:0] job_q[$];
  logic [37:0] last_job = '0;
  logic [37:0] mon_act;
  logic        en_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic        rst_prev = 1'b0;

  int set_lat = 5;
  bit set_mute = 1'b0;
  bit stray_req = 1'b0;
  int exp_done = 0;
  int pend = 0;

  set_dispatch #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_central  (in_central),
    .in_radius   (in_radius),
    .in_mode     (in_mode),
    .set_busy    (set_busy),
    .set_valid   (set_valid),
    .set_en      (set_en),
    .set_central (set_central),
    .set_radius  (set_radius),
    .set_mode    (set_mode),
    .done_cnt    (done_cnt),
    .tmo_err     (tmo_err),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every set_en must match the oldest queued job; otherwise the
  // SET-side payload must hold the last issued job.
  always @(negedge clk) begin
    mon_act = {set_central, set_radius, set_mode};
    if (rst_prev) begin
      job_q.delete();
      last_job = '0;
    end
    if (set_en) begin
      check("en_width", 64'(en_prev), 64'd0);
      check("en_while_busy", 64'(busy_prev), 64'd0);
      if (job_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_en: got job %0h expected no issue at %0t", mon_act, $time);
      end else begin
        last_job = job_q.pop_front();
        check("issue_job", 64'(mon_act), 64'(last_job));
      end
    end else begin
      check("hold_job", 64'(mon_act), 64'(last_job));
    end
    en_prev   = set_en;
    busy_prev = set_busy;
    rst_prev  = rst;
  end

  // SET model: answers each strobe after set_lat cycles unless muted
  initial begin
    forever begin
      @(posedge clk);
      #2;
      set_valid = 1'b0;
      if (rst) begin
        pend     = 0;
        exp_done = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            set_valid = 1'b1;
            exp_done++;
          end
        end
        if (stray_req) set_valid = 1'b1;
        if (set_en && !set_mute) pend = set_lat;
      end
      stray_req = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [37:0] rand_job();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  // Offers one job for one cycle; the model decides acceptance
  task automatic push_job(input logic [37:0] j, output bit acc);
    bit er;
    in_valid = 1'b1;
    {in_central, in_radius, in_mode} = j;
    sample();
    er = (job_q.size() < DEPTH) && !rst;
    check("in_ready", 64'(in_ready), 64'(er));
    acc = er;
    @(posedge clk);
    if (acc) job_q.push_back(j);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      sample();
      n++;
    end while (!(idle === 1'b1 && job_q.size() == 0) && n < budget);
    check("idle_reached", 64'(idle === 1'b1 && job_q.size() == 0), 64'd1);
    check("done_cnt", 64'(done_cnt), 64'(8'(exp_done)));
  endtask

  task automatic wait_en(input int budget);
    int n;
    n = 0;
    do begin
      sample();
      n++;
    end while (set_en !== 1'b1 && n < budget);
    check("en_seen", 64'(set_en), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    // Reset values
    sample();
    check("rst_en", 64'(set_en), 64'd0);
    check("rst_payload", 64'({set_central, set_radius, set_mode}), 64'd0);
    check("rst_done", 64'(done_cnt), 64'd0);
    check("rst_tmo", 64'(tmo_err), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ready", 64'(in_ready), 64'd0);
    cyc();
    rst = 1'b0;
    sample();
    check("post_rst_ready", 64'(in_ready), 64'd1);
    cyc();

    // Single job: strobe two cycles after push, payload held through WAIT
    set_lat = 5;
    push_job({24'h444444, 12'h333, 2'd0}, acc);
    sample();
    check("t1_en_c1", 64'(set_en), 64'd0);
    sample();
    check("t1_en_c2", 64'(set_en), 64'd1);
    for (int k = 3; k <= 7; k++) begin
      sample();
      check("t1_en_wait", 64'(set_en), 64'd0);
      check("t1_payload", 64'({set_central, set_radius, set_mode}), 64'({24'h444444, 12'h333, 2'd0}));
      check("t1_done_wait", 64'(done_cnt), 64'd0);
    end
    sample();
    check("t1_done", 64'(done_cnt), 64'd1);
    check("t1_idle_gap", 64'(idle), 64'd0);
    sample();
    check("t1_idle", 64'(idle), 64'd1);
    cyc();

    // Fill while SET busy: fifth job refused, nothing issues until release
    set_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_job(rand_job(), acc);
    for (int i = 0; i < 10; i++) begin
      sample();
      check("t2_full", 64'(in_ready), 64'd0);
      check("t2_no_en", 64'(set_en), 64'd0);
      cyc();
    end
    set_busy = 1'b0;
    wait_idle(500);
    cyc();

    // Push and issue in the same cycle at DEPTH-1, then refill to full
    set_lat  = 3;
    set_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_job(rand_job(), acc);
    set_busy = 1'b0;
    push_job(rand_job(), acc);
    set_busy = 1'b1;
    push_job(rand_job(), acc);
    push_job(rand_job(), acc);
    set_busy = 1'b0;
    wait_idle(500);
    cyc();

    // Stray result strobe while idle
    stray_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t6_no_en", 64'(set_en), 64'd0);
      cyc();
    end
    check("t6_done", 64'(done_cnt), 64'(8'(exp_done)));

    // Watchdog: SET never answers
    set_mute = 1'b1;
    push_job(rand_job(), acc);
    push_job(rand_job(), acc);
    wait_en(20);
    for (int k = 1; k <= TMO; k++) begin
      sample();
      if (k == TMO) check("t4_tmo_early", 64'(tmo_err), 64'd0);
    end
    sample();
    check("t4_tmo", 64'(tmo_err), 64'd1);
    check("t4_done", 64'(done_cnt), 64'(8'(exp_done)));
    set_mute = 1'b0;
    sample();
    check("t4_next_en_c1", 64'(set_en), 64'd0);
    sample();
    check("t4_next_en_c2", 64'(set_en), 64'd1);
    wait_idle(500);
    check("t4_tmo_sticky", 64'(tmo_err), 64'd1);
    cyc();

    // Reset while waiting with three jobs queued
    set_lat = 50;
    for (int i = 0; i < 4; i++) push_job(rand_job(), acc);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sample();
    check("t5_en", 64'(set_en), 64'd0);
    check("t5_done", 64'(done_cnt), 64'd0);
    check("t5_idle", 64'(idle), 64'd1);
    check("t5_ready", 64'(in_ready), 64'd1);
    check("t5_tmo", 64'(tmo_err), 64'd0);
    cyc();
    stray_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("t5_no_en", 64'(set_en), 64'd0);
      cyc();
    end
    check("t5_late_valid", 64'(done_cnt), 64'd0);

    // Random traffic with random busy and latency
    for (int n = 0; n < 300; n++) begin
      set_busy = ($urandom_range(0, 3) == 0);
      set_lat  = int'($urandom_range(1, 8));
      if ($urandom_range(0, 2) != 0) push_job(rand_job(), acc);
      else cyc();
    end
    set_busy = 1'b0;
    wait_idle(2000);
    check("rand_tmo", 64'(tmo_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
